// File: rtl/issue_queue_pkg.sv
// Shared types and sizing for the issue queue: renamed instruction payload,
// queue slot layout and the source-2 physical register helper.
package issue_queue_pkg;

   localparam int IQ_ENTRIES   = 8;
   localparam int NUM_PHYS_REG = 64;
   localparam int NUM_ARCH_REG = 32;

   localparam int PREG_W = $clog2(NUM_PHYS_REG);
   localparam int AREG_W = $clog2(NUM_ARCH_REG);
   localparam int IDX_W  = $clog2(IQ_ENTRIES);
   localparam int CNT_W  = IDX_W + 1;
   localparam int IMM_W  = 16;

   typedef struct packed {
      logic [5:0]        opcode;
      logic [3:0]        flags;
      logic [3:0]        bcc_op;
      logic              imm;
      logic              w_v;
      logic [PREG_W-1:0] dest_id;
      logic [PREG_W-1:0] source_1;
      logic [IMM_W-1:0]  source2_imm;
   } renamed_instruction_t;

   localparam int RENAMED_INSTRUCTION_WIDTH = $bits(renamed_instruction_t);

   typedef struct packed {
      logic                 valid;
      logic                 s1_rdy;
      logic                 s2_rdy;
      renamed_instruction_t payload;
   } iq_entry_t;

   // Source 2 shares its field with the immediate; the low bits name the preg.
   function automatic logic [PREG_W-1:0] src2_preg(input renamed_instruction_t ins);
      return ins.source2_imm[PREG_W-1:0];
   endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Rename/writeback/issue handshake bundle between the pipeline and the issue queue.
interface issue_queue_if
   import issue_queue_pkg::*;
();

   renamed_instruction_t renamed_i;
   logic                 renamed_v_i;
   logic                 issue_rename_ready_o;
   logic                 wb_v_i;
   logic [PREG_W-1:0]    wb_preg_i;
   logic                 flush_i;
   logic                 fu_ready_i;
   renamed_instruction_t issue_o;
   logic                 issue_v_o;
   logic [CNT_W-1:0]     count_o;

   modport master (
      output renamed_i, renamed_v_i, wb_v_i, wb_preg_i, flush_i, fu_ready_i,
      input  issue_rename_ready_o, issue_o, issue_v_o, count_o
   );

   modport slave (
      input  renamed_i, renamed_v_i, wb_v_i, wb_preg_i, flush_i, fu_ready_i,
      output issue_rename_ready_o, issue_o, issue_v_o, count_o
   );

endinterface

// File: rtl/issue_queue_preg_scoreboard.sv
// Physical register readiness bits: set on writeback, cleared on allocation,
// all ones after reset or flush; two read ports with same-cycle writeback bypass.
module preg_scoreboard
   import issue_queue_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              flush_i,
   input  logic              wb_v_i,
   input  logic [PREG_W-1:0] wb_preg_i,
   input  logic              alloc_v_i,
   input  logic [PREG_W-1:0] alloc_preg_i,
   input  logic [PREG_W-1:0] rd_a_preg_i,
   input  logic [PREG_W-1:0] rd_b_preg_i,
   output logic              rd_a_rdy_o,
   output logic              rd_b_rdy_o
);

   logic [NUM_PHYS_REG-1:0] sb_q;

   // NOTE: non-blocking updates to the same bit resolve last-writer-wins, so the
   // allocation clear placed after the writeback set takes priority.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i || flush_i) begin
         sb_q <= '1;
      end else begin
         if (wb_v_i)    sb_q[wb_preg_i]    <= 1'b1;
         if (alloc_v_i) sb_q[alloc_preg_i] <= 1'b0;
      end
   end

   assign rd_a_rdy_o = sb_q[rd_a_preg_i] | (wb_v_i && (wb_preg_i == rd_a_preg_i));
   assign rd_b_rdy_o = sb_q[rd_b_preg_i] | (wb_v_i && (wb_preg_i == rd_b_preg_i));

endmodule

// File: rtl/issue_queue.sv
// Collapsing issue queue: in-order allocate at the tail, oldest-ready issue from
// the head side, writeback wakeup, full drain on flush.
module issue_queue
   import issue_queue_pkg::*;
(
   input  logic clk_i,
   input  logic reset_n_i,
   issue_queue_if.slave bus
);

   iq_entry_t        q_q   [IQ_ENTRIES];
   iq_entry_t        q_n   [IQ_ENTRIES];
   iq_entry_t        q_ext [IQ_ENTRIES+1];
   iq_entry_t        new_entry;
   iq_entry_t        entry;
   logic [CNT_W-1:0] count_q, count_n, enq_idx;
   logic [IQ_ENTRIES-1:0] rdy_vec;
   logic [IDX_W-1:0] sel_idx;
   logic             any_rdy, fire, enq, s1_sb_rdy, s2_sb_rdy;

   // Ready depends only on registered occupancy, never on this cycle's issue.
   assign bus.issue_rename_ready_o = (count_q < CNT_W'(IQ_ENTRIES));
   assign enq = bus.renamed_v_i & bus.issue_rename_ready_o & ~bus.flush_i;

   preg_scoreboard u_sb (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .flush_i      (bus.flush_i),
      .wb_v_i       (bus.wb_v_i),
      .wb_preg_i    (bus.wb_preg_i),
      .alloc_v_i    (enq & bus.renamed_i.w_v),
      .alloc_preg_i (bus.renamed_i.dest_id),
      .rd_a_preg_i  (bus.renamed_i.source_1),
      .rd_b_preg_i  (src2_preg(bus.renamed_i)),
      .rd_a_rdy_o   (s1_sb_rdy),
      .rd_b_rdy_o   (s2_sb_rdy)
   );

   always_comb begin
      for (int i = 0; i < IQ_ENTRIES; i++)
         rdy_vec[i] = q_q[i].valid & q_q[i].s1_rdy & q_q[i].s2_rdy;
   end

   // NOTE: combinational logic uses blocking assignments; scanning from the top
   // down lets the lowest ready index be the last one written.
   always_comb begin
      sel_idx = '0;
      any_rdy = 1'b0;
      for (int i = IQ_ENTRIES-1; i >= 0; i--) begin
         if (rdy_vec[i]) begin
            sel_idx = IDX_W'(i);
            any_rdy = 1'b1;
         end
      end
   end

   assign bus.issue_v_o = any_rdy & ~bus.flush_i;
   assign bus.issue_o   = q_q[sel_idx].payload;
   assign bus.count_o   = count_q;
   assign fire          = bus.issue_v_o & bus.fu_ready_i;
   assign enq_idx       = count_q - CNT_W'(fire);
   assign count_n       = count_q + CNT_W'(enq) - CNT_W'(fire);

   always_comb begin
      new_entry.valid   = 1'b1;
      new_entry.payload = bus.renamed_i;
      new_entry.s1_rdy  = s1_sb_rdy;
      new_entry.s2_rdy  = bus.renamed_i.imm | s2_sb_rdy;
   end

   // Extra empty slot past the top feeds the shift into the last position.
   always_comb begin
      for (int i = 0; i < IQ_ENTRIES; i++) q_ext[i] = q_q[i];
      q_ext[IQ_ENTRIES] = '0;
   end

   always_comb begin
      entry = '0;
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         entry = (fire && (IDX_W'(i) >= sel_idx)) ? q_ext[i+1] : q_q[i];
         if (bus.wb_v_i && (entry.payload.source_1 == bus.wb_preg_i))
            entry.s1_rdy = 1'b1;
         if (bus.wb_v_i && (src2_preg(entry.payload) == bus.wb_preg_i))
            entry.s2_rdy = 1'b1;
         if (enq && (CNT_W'(i) == enq_idx))
            entry = new_entry;
         q_n[i] = entry;
      end
   end

   // NOTE: only the valid bits need clearing; payload and ready bits of an
   // invalid slot are always rewritten before they are looked at.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i || bus.flush_i) begin
         count_q <= '0;
         for (int i = 0; i < IQ_ENTRIES; i++) q_q[i].valid <= 1'b0;
      end else begin
         count_q <= count_n;
         for (int i = 0; i < IQ_ENTRIES; i++) q_q[i] <= q_n[i];
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a queue-based reference model checked every cycle.
module tb_issue_queue;
   import issue_queue_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   model_ok = 1'b0;

   issue_queue_if bus ();

   issue_queue dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic renamed_instruction_t mk(input logic [5:0] op, input logic [PREG_W-1:0] dest,
                                                input logic [PREG_W-1:0] s1, input logic [PREG_W-1:0] s2,
                                                input logic imm, input logic w_v);
      renamed_instruction_t r;
      r             = '0;
      r.opcode      = op;
      r.flags       = op[3:0];
      r.bcc_op      = ~op[3:0];
      r.imm         = imm;
      r.w_v         = w_v;
      r.dest_id     = dest;
      r.source_1    = s1;
      r.source2_imm = {{(IMM_W-PREG_W){1'b0}}, s2};
      return r;
   endfunction

   // Reference model: age-ordered list of waiting instructions plus a readiness
   // bit per physical register. Checks the DUT, then advances to the next edge.
   typedef struct {
      renamed_instruction_t p;
      bit                   r1;
      bit                   r2;
   } m_ent_t;

   m_ent_t mq [$];
   bit     msb [NUM_PHYS_REG];

   always @(negedge clk) begin : model
      int                sel;
      bit                exp_v, m_fire, m_enq;
      m_ent_t            ne;
      logic [PREG_W-1:0] a, b;
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      exp_v = (sel >= 0) && !bus.flush_i;
      if (model_ok) begin
         check("m_count", bus.count_o, mq.size());
         check("m_ready", bus.issue_rename_ready_o, mq.size() < IQ_ENTRIES);
         check("m_issue_v", bus.issue_v_o, exp_v);
         if (exp_v) check("m_issue_o", bus.issue_o, mq[sel].p);
      end
      m_fire = exp_v && bus.fu_ready_i;
      m_enq  = bus.renamed_v_i && (mq.size() < IQ_ENTRIES) && !bus.flush_i;
      if (!rst_n || bus.flush_i) begin
         mq.delete();
         foreach (msb[i]) msb[i] = 1'b1;
      end else begin
         a    = bus.renamed_i.source_1;
         b    = bus.renamed_i.source2_imm[PREG_W-1:0];
         ne.p  = bus.renamed_i;
         ne.r1 = msb[a] || (bus.wb_v_i && bus.wb_preg_i == a);
         ne.r2 = bus.renamed_i.imm || msb[b] || (bus.wb_v_i && bus.wb_preg_i == b);
         if (m_fire) mq.delete(sel);
         if (bus.wb_v_i) begin
            foreach (mq[i]) begin
               if (mq[i].p.source_1 == bus.wb_preg_i) mq[i].r1 = 1'b1;
               if (mq[i].p.source2_imm[PREG_W-1:0] == bus.wb_preg_i) mq[i].r2 = 1'b1;
            end
            msb[bus.wb_preg_i] = 1'b1;
         end
         if (m_enq) begin
            mq.push_back(ne);
            if (ne.p.w_v) msb[ne.p.dest_id] = 1'b0;
         end
      end
      model_ok = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      bus.renamed_i   = '0;
      bus.renamed_v_i = 1'b0;
      bus.wb_v_i      = 1'b0;
      bus.wb_preg_i   = '0;
      bus.flush_i     = 1'b0;
      bus.fu_ready_i  = 1'b0;
      tick();
      tick();
      check("rst_count", bus.count_o, 0);
      check("rst_issue_v", bus.issue_v_o, 0);
      check("rst_ready", bus.issue_rename_ready_o, 1);
      rst_n = 1'b1;

      // Independent op issues the cycle after enqueue.
      bus.renamed_i = mk(6'h01, 6'd40, 6'd1, 6'd2, 1'b0, 1'b1);
      bus.renamed_v_i = 1'b1;
      tick();
      bus.renamed_v_i = 1'b0;
      check("ind_count", bus.count_o, 1);
      check("ind_v", bus.issue_v_o, 1);
      check("ind_dest", bus.issue_o.dest_id, 40);
      bus.fu_ready_i = 1'b1;
      tick();
      check("ind_drain", bus.count_o, 0);
      check("ind_v_after", bus.issue_v_o, 0);

      // Dependency through p40 resolved by writeback.
      bus.renamed_i = mk(6'h02, 6'd40, 6'd3, 6'd4, 1'b0, 1'b1);
      bus.renamed_v_i = 1'b1;
      tick();
      check("dep_a_v", bus.issue_v_o, 1);
      check("dep_a_op", bus.issue_o.opcode, 6'h02);
      bus.renamed_i = mk(6'h03, 6'd43, 6'd40, 6'd0, 1'b1, 1'b1);
      tick();
      bus.renamed_v_i = 1'b0;
      check("dep_b_wait", bus.issue_v_o, 0);
      check("dep_count", bus.count_o, 1);
      tick();
      check("dep_b_still", bus.issue_v_o, 0);
      bus.wb_v_i = 1'b1;
      bus.wb_preg_i = 6'd40;
      tick();
      bus.wb_v_i = 1'b0;
      check("dep_b_wake", bus.issue_v_o, 1);
      check("dep_b_op", bus.issue_o.opcode, 6'h03);
      tick();
      check("dep_done", bus.count_o, 0);

      // Same-cycle writeback bypass into a new entry.
      bus.renamed_i = mk(6'h04, 6'd41, 6'd5, 6'd0, 1'b1, 1'b1);
      bus.renamed_v_i = 1'b1;
      tick();
      bus.renamed_v_i = 1'b0;
      check("byp_x_v", bus.issue_v_o, 1);
      tick();
      bus.renamed_i = mk(6'h05, 6'd44, 6'd41, 6'd0, 1'b1, 1'b0);
      bus.renamed_v_i = 1'b1;
      bus.wb_v_i = 1'b1;
      bus.wb_preg_i = 6'd41;
      tick();
      bus.renamed_v_i = 1'b0;
      bus.wb_v_i = 1'b0;
      check("byp_c_v", bus.issue_v_o, 1);
      check("byp_c_op", bus.issue_o.opcode, 6'h05);
      tick();
      check("byp_done", bus.count_o, 0);

      // Allocation clear beats a same-cycle writeback of the same preg.
      bus.renamed_i = mk(6'h06, 6'd30, 6'd1, 6'd2, 1'b0, 1'b1);
      bus.renamed_v_i = 1'b1;
      bus.wb_v_i = 1'b1;
      bus.wb_preg_i = 6'd30;
      tick();
      bus.wb_v_i = 1'b0;
      check("clr_d_op", bus.issue_o.opcode, 6'h06);
      bus.renamed_i = mk(6'h07, 6'd45, 6'd30, 6'd0, 1'b1, 1'b0);
      tick();
      bus.renamed_v_i = 1'b0;
      check("clr_wins", bus.issue_v_o, 0);
      bus.wb_v_i = 1'b1;
      bus.wb_preg_i = 6'd30;
      tick();
      bus.wb_v_i = 1'b0;
      check("clr_e_op", bus.issue_o.opcode, 6'h07);
      tick();

      // Fill to capacity under backpressure, then drain in age order.
      bus.fu_ready_i = 1'b0;
      bus.renamed_v_i = 1'b1;
      for (int k = 0; k < IQ_ENTRIES; k++) begin
         bus.renamed_i = mk(6'(k + 8), 6'(10 + k), 6'd1, 6'd2, 1'b0, 1'b0);
         tick();
      end
      check("full_ready", bus.issue_rename_ready_o, 0);
      check("full_count", bus.count_o, 8);
      check("full_head", bus.issue_o.opcode, 6'd8);
      bus.renamed_i = mk(6'h20, 6'd9, 6'd1, 6'd2, 1'b0, 1'b0);
      tick();
      check("full_ignored", bus.count_o, 8);
      check("full_hold", bus.issue_o.opcode, 6'd8);
      bus.fu_ready_i = 1'b1;
      tick();
      bus.renamed_v_i = 1'b0;
      check("full_no_enq", bus.count_o, 7);
      for (int k = 1; k < IQ_ENTRIES; k++) begin
         check("drain_order", bus.issue_o.opcode, 6'(8 + k));
         tick();
      end
      check("drain_empty", bus.count_o, 0);

      // Flush with waiting entries and a simultaneous enqueue attempt.
      bus.fu_ready_i = 1'b0;
      bus.renamed_v_i = 1'b1;
      bus.renamed_i = mk(6'h30, 6'd20, 6'd1, 6'd2, 1'b0, 1'b1);
      tick();
      for (int k = 1; k < 5; k++) begin
         bus.renamed_i = mk(6'(8'h30 + k), 6'(20 + k), 6'd43, 6'd2, 1'b0, 1'b1);
         tick();
      end
      check("fl_count", bus.count_o, 5);
      check("fl_head", bus.issue_o.opcode, 6'h30);
      bus.renamed_i = mk(6'h3f, 6'd25, 6'd1, 6'd2, 1'b0, 1'b1);
      bus.flush_i = 1'b1;
      bus.fu_ready_i = 1'b1;
      #1;
      check("fl_cycle_v", bus.issue_v_o, 0);
      tick();
      bus.flush_i = 1'b0;
      bus.renamed_v_i = 1'b0;
      check("fl_count0", bus.count_o, 0);
      check("fl_ready", bus.issue_rename_ready_o, 1);
      bus.renamed_i = mk(6'h3e, 6'd26, 6'd20, 6'd24, 1'b0, 1'b0);
      bus.renamed_v_i = 1'b1;
      tick();
      bus.renamed_v_i = 1'b0;
      check("fl_sb_ones", bus.issue_v_o, 1);
      tick();
      check("fl_done", bus.count_o, 0);

      // Reset in the middle of operation discards contents.
      bus.fu_ready_i = 1'b0;
      bus.renamed_v_i = 1'b1;
      bus.renamed_i = mk(6'h11, 6'd50, 6'd1, 6'd2, 1'b0, 1'b1);
      tick();
      tick();
      check("mr_count2", bus.count_o, 2);
      bus.renamed_v_i = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mr_count0", bus.count_o, 0);
      check("mr_issue_v", bus.issue_v_o, 0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
